// File: rtl/line_clear_ctrl_if.sv
// Request/result bundle between the game FSM (master) and line_clear_ctrl (slave).
// start is a single-cycle pulse taken only while busy = 0; results are valid after done falls.
interface line_clear_ctrl_if #(
  parameter int ROWS = 22,
  parameter int COLS = 10
);
  logic                       start;
  logic [ROWS-1:0][COLS-1:0]  grid_i;
  logic                       busy;
  logic                       done;
  logic [ROWS-1:0][COLS-1:0]  grid_o;
  logic [4:0]                 lines_o;

  modport master (
    output start, grid_i,
    input  busy, done, grid_o, lines_o
  );

  modport slave (
    input  start, grid_i,
    output busy, done, grid_o, lines_o
  );
endinterface

// File: rtl/line_clear_ctrl.sv
// Bottom-up row-clear sequencer for the stored playfield; collapses full rows one per SHIFT.
// Optional running score port enabled by `LINE_CLEAR_SCORE_EN.
module line_clear_ctrl #(
  parameter int ROWS = 22,
  parameter int COLS = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  line_clear_ctrl_if.slave      bus,
`ifdef LINE_CLEAR_SCORE_EN
  output logic [15:0]           score_o,
`endif
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  state_t                    state;
  logic [ROWS-1:0][COLS-1:0] work;
  logic [4:0]                row;
  logic [4:0]                cnt;
  logic                      row_full;

  assign row_full  = &work[row];
  assign dbg_state = state;

`ifdef LINE_CLEAR_SCORE_EN
  logic [3:0]  points;
  logic [16:0] score_sum;

  always_comb begin
    points = 4'd0;
    case (cnt)
      5'd0:    points = 4'd0;
      5'd1:    points = 4'd1;
      5'd2:    points = 4'd3;
      5'd3:    points = 4'd5;
      default: points = 4'd8;
    endcase
    score_sum = {1'b0, score_o} + 17'(points);
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      work        <= '0;
      row         <= '0;
      cnt         <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.grid_o  <= '0;
      bus.lines_o <= '0;
`ifdef LINE_CLEAR_SCORE_EN
      score_o     <= '0;
`endif
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            work     <= bus.grid_i;
            row      <= LAST_ROW;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (row_full) begin
            state <= SHIFT;
          end else if (row == 5'd0) begin
            bus.done <= 1'b1;
            state    <= DONE;
          end else begin
            row <= row - 5'd1;
          end
        end
        SHIFT: begin
          // Row pointer stays put so the row that dropped in is rechecked.
          for (int r = 1; r < ROWS; r++) begin
            if (5'(r) <= row) work[r] <= work[r-1];
          end
          work[0] <= '0;
          cnt     <= cnt + 5'd1;
          state   <= SCAN;
        end
        DONE: begin
          bus.grid_o  <= work;
          bus.lines_o <= cnt;
          bus.busy    <= 1'b0;
`ifdef LINE_CLEAR_SCORE_EN
          score_o     <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
`endif
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
